// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - core-to-data-memory port bundle
interface dmem_responder_if #(
  parameter int ADDR_W = 10,
  parameter int GPIO_W = 8
);
  logic [ADDR_W-1:0] DIR_DMEM;
  logic [31:0]       DATA_WRITE_DMEM;
  logic              READ;
  logic              WRITE;
  logic [31:0]       DATA_READ_DMEM;
  logic              BUSY;
  logic [GPIO_W-1:0] GPIO_OUT;

  modport master (
    output DIR_DMEM, DATA_WRITE_DMEM, READ, WRITE,
    input  DATA_READ_DMEM, BUSY, GPIO_OUT
  );

  modport slave (
    input  DIR_DMEM, DATA_WRITE_DMEM, READ, WRITE,
    output DATA_READ_DMEM, BUSY, GPIO_OUT
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word RAM plus GPIO/cycle/status/error MMIO with zero-fill sweep
module dmem_responder #(
  parameter int ADDR_W         = 10,
  parameter int GPIO_W         = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic              CLK,
  input logic              RESET,
  dmem_responder_if.slave  bus
);
  localparam int RAM_WORDS = (1 << ADDR_W) - 4;
  localparam logic [ADDR_W-1:0] LAST_RAM = ADDR_W'(RAM_WORDS - 1);
  localparam logic [ADDR_W-1:0] A_GPIO   = ADDR_W'(RAM_WORDS);
  localparam logic [ADDR_W-1:0] A_CYCLE  = ADDR_W'(RAM_WORDS + 1);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(RAM_WORDS + 2);
  localparam logic [ADDR_W-1:0] A_ERR    = ADDR_W'(RAM_WORDS + 3);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [GPIO_W-1:0] gpio_q, gpio_d;
  logic [31:0]       cycle_q, cycle_d;
  logic [7:0]        err_q, err_d;

  logic [31:0]       mem [RAM_WORDS];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic [31:0]       rdata;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    gpio_d    = gpio_q;
    cycle_d   = cycle_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_waddr = bus.DIR_DMEM;
    mem_wdata = bus.DATA_WRITE_DMEM;
    case (state_q)
      ST_INIT: begin
        // Core traffic is dropped during the sweep; any attempt is an error.
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = 32'h0;
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (clr_ptr_q == LAST_RAM) state_d = ST_READY;
        if ((bus.READ || bus.WRITE) && err_q != 8'hFF) err_d = err_q + 8'd1;
      end
      ST_READY: begin
        cycle_d = cycle_q + 32'd1;
        if (bus.READ && bus.WRITE && err_q != 8'hFF) err_d = err_q + 8'd1;
        if (bus.WRITE) begin
          // Assignments below intentionally override the increments above.
          case (bus.DIR_DMEM)
            A_GPIO:   gpio_d  = bus.DATA_WRITE_DMEM[GPIO_W-1:0];
            A_CYCLE:  cycle_d = bus.DATA_WRITE_DMEM;
            A_STATUS: ;
            A_ERR:    err_d   = 8'h00;
            default:  mem_we  = 1'b1;
          endcase
        end
      end
      default: state_d = ST_READY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= CLEAR_ON_RESET ? ST_INIT : ST_READY;
      clr_ptr_q <= '0;
      gpio_q    <= '0;
      cycle_q   <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      gpio_q    <= gpio_d;
      cycle_q   <= cycle_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Reads see pre-edge state, so a same-cycle write is not bypassed.
  always_comb begin
    rdata = 32'h0;
    if (state_q == ST_READY && bus.READ) begin
      case (bus.DIR_DMEM)
        A_GPIO:   rdata = 32'(gpio_q);
        A_CYCLE:  rdata = cycle_q;
        A_STATUS: rdata = {30'b0, state_q == ST_READY, state_q == ST_INIT};
        A_ERR:    rdata = 32'(err_q);
        default:  rdata = mem[bus.DIR_DMEM];
      endcase
    end
  end

  assign bus.DATA_READ_DMEM = rdata;
  assign bus.BUSY           = (state_q == ST_INIT);
  assign bus.GPIO_OUT       = gpio_q;
endmodule
